// File: rtl/load_pkg.sv
// load_pkg: load opcode encodings, FSM state type and the alignment rule shared by the load unit.
package load_pkg;

    localparam logic [2:0] OP_LB  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LW  = 3'b011;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_LHU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Unused opcodes (010/110/111) are words, so they need full word alignment too.
    function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] a);
        return (op == OP_LH || op == OP_LHU) ? a[0] :
               (op == OP_LB || op == OP_LBU) ? 1'b0 : (a != 2'b00);
    endfunction

endpackage

// File: rtl/load_align_ext.sv
// load_align_ext: little-endian byte/halfword lane select with sign or zero extension.
module load_align_ext
    import load_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  addr,
    input  logic [31:0] word,
    output logic [31:0] ext
);

    logic [7:0]  b;
    logic [15:0] h;

    assign b   = word[{addr, 3'b000} +: 8];
    assign h   = addr[1] ? word[31:16] : word[15:0];
    assign ext = (op == OP_LB)  ? {{24{b[7]}}, b}  :
                 (op == OP_LH)  ? {{16{h[15]}}, h} :
                 (op == OP_LBU) ? {24'h0, b}       :
                 (op == OP_LHU) ? {16'h0, h}       : word;

endmodule

// File: rtl/mem_load_unit.sv
// mem_load_unit: MEM-stage load FSM (IDLE/READ/RESP) with memory req/ack and result valid/ready.
// Defining LOAD_ADDR_CHECK_EN adds resp_err and skips memory for misaligned requests.
module mem_load_unit
    import load_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    output logic        mem_rd_en,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        resp_valid,
    input  logic        resp_ready,
`ifdef LOAD_ADDR_CHECK_EN
    output logic        resp_err,
`endif
    output logic [31:0] resp_data
);

    state_t      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] addr_q, addr_d, data_q, data_d, ext;
`ifdef LOAD_ADDR_CHECK_EN
    logic        err_q, err_d;
`endif

    load_align_ext u_align (
        .op   (op_q),
        .addr (addr_q[1:0]),
        .word (mem_rdata),
        .ext  (ext)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            addr_q  <= '0;
            data_q  <= '0;
`ifdef LOAD_ADDR_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
`ifdef LOAD_ADDR_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        addr_d     = addr_q;
        data_d     = data_q;
`ifdef LOAD_ADDR_CHECK_EN
        err_d      = err_q;
`endif
        req_ready  = 1'b0;
        mem_rd_en  = 1'b0;
        resp_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    op_d    = req_op;
                    addr_d  = req_addr;
                    state_d = ST_READ;
`ifdef LOAD_ADDR_CHECK_EN
                    err_d   = 1'b0;
                    if (is_misaligned(req_op, req_addr[1:0])) begin
                        state_d = ST_RESP;
                        data_d  = '0;
                        err_d   = 1'b1;
                    end
`endif
                end
            end
            ST_READ: begin
                mem_rd_en = 1'b1;
                if (mem_ack) begin
                    data_d  = ext;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign mem_addr  = mem_rd_en ? {addr_q[31:2], 2'b00} : 32'h0;
    assign resp_data = data_q;
`ifdef LOAD_ADDR_CHECK_EN
    assign resp_err  = err_q;
`endif

endmodule

// File: tb/tb_mem_load_unit.sv
// tb_mem_load_unit: directed self-checking bench for mem_load_unit; covers LOAD_ADDR_CHECK_EN when defined.
module tb_mem_load_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic        mem_rd_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata = 32'hDEAD_BEEF;
    logic        mem_ack = 1'b0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic        resp_err;
    logic [31:0] resp_data;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

`ifndef LOAD_ADDR_CHECK_EN
    assign resp_err = 1'b0;
`endif

    mem_load_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
`ifdef LOAD_ADDR_CHECK_EN
        .resp_err   (resp_err),
`endif
        .resp_data  (resp_data)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change just after the falling edge; outputs are sampled 1ns later.
    task automatic tick();
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = 32'hDEAD_BEEF;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_load(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] rdata,
                           input int waits, input int hold, input logic [31:0] exp);
        tick();
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i <= waits; i++) begin
            settle();
            check("read_en", {31'h0, mem_rd_en}, 32'h1);
            check("read_addr", mem_addr, {addr[31:2], 2'b00});
            check("busy_ready", {31'h0, req_ready}, 32'h0);
            check("busy_valid", {31'h0, resp_valid}, 32'h0);
            if (i == waits) begin
                mem_ack   = 1'b1;
                mem_rdata = rdata;
            end
            @(negedge clk);
            if (i != waits) mem_rdata = 32'hDEAD_BEEF;
        end
        mem_ack   = 1'b0;
        mem_rdata = 32'hDEAD_BEEF;
        for (int h = 0; h <= hold; h++) begin
            settle();
            check("resp_valid", {31'h0, resp_valid}, 32'h1);
            check("resp_data", resp_data, exp);
            check("resp_rd_en", {31'h0, mem_rd_en}, 32'h0);
            check("resp_req_ready", {31'h0, req_ready}, 32'h0);
            check("resp_err", {31'h0, resp_err}, 32'h0);
            if (h == hold) resp_ready = 1'b1;
            tick();
        end
        resp_ready = 1'b0;
        settle();
        check("idle_ready", {31'h0, req_ready}, 32'h1);
        check("idle_valid", {31'h0, resp_valid}, 32'h0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        settle();
        check("rst_valid", {31'h0, resp_valid}, 32'h0);
        check("rst_rd_en", {31'h0, mem_rd_en}, 32'h0);
        check("rst_data", resp_data, 32'h0);
        rst_n = 1'b1;
        tick();
        settle();
        check("rel_ready", {31'h0, req_ready}, 32'h1);
        check("rel_err", {31'h0, resp_err}, 32'h0);

        tick();
        mem_ack   = 1'b1;
        mem_rdata = 32'h1234_5678;
        tick();
        settle();
        check("idle_ack_valid", {31'h0, resp_valid}, 32'h0);
        check("idle_ack_ready", {31'h0, req_ready}, 32'h1);

        do_load(3'b000, 32'h0000_1003, 32'h8011_2233, 0, 0, 32'hFFFF_FF80);
        do_load(3'b100, 32'h0000_1003, 32'h8011_2233, 0, 0, 32'h0000_0080);
        do_load(3'b101, 32'h0000_1002, 32'h8001_1234, 0, 0, 32'h0000_8001);
        do_load(3'b001, 32'h0000_1000, 32'h8001_1234, 0, 0, 32'h0000_1234);
        do_load(3'b000, 32'h0000_2001, 32'h8001_1234, 1, 0, 32'h0000_0012);
        do_load(3'b001, 32'h0000_2002, 32'h8001_1234, 0, 1, 32'hFFFF_8001);
        do_load(3'b100, 32'h0000_2000, 32'h0000_00F7, 0, 0, 32'h0000_00F7);
        do_load(3'b011, 32'h0000_3000, 32'h8001_1234, 3, 4, 32'h8001_1234);
        do_load(3'b111, 32'h0000_3004, 32'hA5A5_5A5A, 0, 0, 32'hA5A5_5A5A);

        // Reset while a read is outstanding, then a stale ack.
        tick();
        req_valid = 1'b1;
        req_op    = 3'b011;
        req_addr  = 32'h0000_3000;
        tick();
        req_valid = 1'b0;
        settle();
        check("mid_read_en", {31'h0, mem_rd_en}, 32'h1);
        rst_n = 1'b0;
        settle();
        check("async_rd_en", {31'h0, mem_rd_en}, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        mem_ack   = 1'b1;
        mem_rdata = 32'h7777_7777;
        tick();
        settle();
        check("late_ack_valid", {31'h0, resp_valid}, 32'h0);
        check("late_ack_ready", {31'h0, req_ready}, 32'h1);
        check("late_ack_rd_en", {31'h0, mem_rd_en}, 32'h0);
        check("late_ack_addr", mem_addr, 32'h0);
        check("late_ack_data", resp_data, 32'h0);

        // Back-to-back with req_valid held high; op 110 is a word load.
        tick();
        req_valid = 1'b1;
        req_op    = 3'b110;
        req_addr  = 32'h0000_4000;
        tick();
        settle();
        check("b2b_rd_en1", {31'h0, mem_rd_en}, 32'h1);
        check("b2b_ready1", {31'h0, req_ready}, 32'h0);
        mem_ack   = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        tick();
        settle();
        check("b2b_valid1", {31'h0, resp_valid}, 32'h1);
        check("b2b_data1", resp_data, 32'hCAFE_F00D);
        check("b2b_ready_hold", {31'h0, req_ready}, 32'h0);
        tick();
        settle();
        check("b2b_no_bypass", {31'h0, mem_rd_en}, 32'h0);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        settle();
        check("b2b_idle", {31'h0, req_ready}, 32'h1);
        tick();
        req_valid = 1'b0;
        settle();
        check("b2b_rd_en2", {31'h0, mem_rd_en}, 32'h1);
        mem_ack   = 1'b1;
        mem_rdata = 32'h1122_3344;
        tick();
        settle();
        check("b2b_data2", resp_data, 32'h1122_3344);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        settle();
        check("b2b_end_ready", {31'h0, req_ready}, 32'h1);

`ifdef LOAD_ADDR_CHECK_EN
        for (int k = 0; k < 2; k++) begin
            tick();
            req_valid = 1'b1;
            req_op    = (k == 0) ? 3'b011 : 3'b101;
            req_addr  = (k == 0) ? 32'h0000_5002 : 32'h0000_5001;
            tick();
            req_valid = 1'b0;
            settle();
            check("mis_rd_en", {31'h0, mem_rd_en}, 32'h0);
            check("mis_valid", {31'h0, resp_valid}, 32'h1);
            check("mis_data", resp_data, 32'h0);
            check("mis_err", {31'h0, resp_err}, 32'h1);
            resp_ready = 1'b1;
            tick();
            resp_ready = 1'b0;
            settle();
            check("mis_idle", {31'h0, req_ready}, 32'h1);
        end
        do_load(3'b011, 32'h0000_5000, 32'h0BAD_F00D, 0, 0, 32'h0BAD_F00D);
`endif

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_load_unit.md
# mem_load_unit

Multi-cycle load unit in the MEM stage of the 54-instruction CPU. Accepts one load request at a time (LB/LBU/LH/LHU/LW), issues a word-aligned read to data memory with a request/acknowledge handshake, then selects the addressed byte or halfword lane. The selected lane is sign- or zero-extended to 32 bits, and the result is held for the write-back stage under a valid/ready handshake.

## Interface
- No parameters. Data and address widths are fixed at 32.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  load request present
- req_ready  out  1  unit can accept a request
- req_op  in  3  load type: 000 LB, 001 LH, 011 LW, 100 LBU, 101 LHU; codes 010/110/111 behave as LW
- req_addr  in  32  byte address
- mem_rd_en  out  1  read strobe to data memory
- mem_addr  out  32  word-aligned read address
- mem_rdata  in  32  read data; valid in the cycle mem_ack is high
- mem_ack  in  1  memory read complete
- resp_valid  out  1  result available
- resp_ready  in  1  write-back consumes result
- resp_data  out  32  extended load result
- resp_err  out  1  address error; present only with LOAD_ADDR_CHECK_EN

## Operation
- FSM states:
  - IDLE: req_ready=1; all other outputs inactive.
  - READ: mem_rd_en=1; mem_addr={addr_q[31:2],2'b00}.
  - RESP: resp_valid=1.
- IDLE→READ on req_valid&&req_ready. req_op and req_addr are captured into op_q and addr_q.
- READ→RESP on mem_ack. The extracted and extended data is registered into resp_data at that edge. mem_rdata is ignored in any cycle where mem_ack is low.
- RESP→IDLE on resp_ready. resp_data and resp_valid stay stable until then.
- Byte lanes are little-endian: byte k = mem_rdata[8k+7:8k], where k=addr_q[1:0]. Halfword = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0].
- Extension:
  - LB/LH replicate bit 7/15 into the upper bits.
  - LBU/LHU fill the upper bits with zero.
  - LW passes the word through unchanged.
- The unit accepts no new request until the current result is consumed. There is no bypass from RESP to READ.
- Reset, asynchronous and possible in any state:
  - State returns to IDLE.
  - mem_rd_en=0, resp_valid=0, resp_data=0, resp_err=0; req_ready=1 after reset release.
  - An in-flight memory access is abandoned. A late mem_ack after reset is ignored because the unit is in IDLE.
- mem_ack arriving in IDLE or RESP is ignored.

## Timing
- Minimum latency: request accepted at edge N, mem_ack high in the following cycle (sampled at edge N+1), resp_valid high from edge N+1. That gives 1 cycle of READ plus a result that is visible before edge N+2.
- Memory wait states extend READ one cycle each. mem_addr and mem_rd_en are held constant throughout.
- resp_ready low holds RESP indefinitely.
- Throughput is at most one load per 3 cycles: IDLE, READ, RESP.

## Configuration
- LOAD_ADDR_CHECK_EN defined:
  - Misaligned requests (LH/LHU with addr[0]=1; LW with addr[1:0]≠0) go IDLE→RESP directly. No memory access is made (mem_rd_en stays 0).
  - Result is resp_data=0, resp_err=1. resp_err is registered alongside resp_data and cleared on the next accepted request.
- LOAD_ADDR_CHECK_EN undefined:
  - No resp_err port.
  - Misalignment is not detected. LH/LHU use addr[1] only, and LW ignores addr[1:0].

## Structure
- Package load_pkg holds:
  - the req_op encodings as localparams (OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU);
  - the FSM state encoding (ST_IDLE, ST_READ, ST_RESP) as a 2-bit typedef.
- Sub-module load_align_ext: purely combinational. Inputs op, addr[1:0], word[31:0]; output ext[31:0]. It performs lane select and extension, and is instantiated once, feeding the resp_data register.

## Test plan
- LB, addr 0x0000_1003, rdata 0x8011_2233, ack after 1 cycle → resp_data 0xFFFF_FF80, mem_addr 0x0000_1000.
- LBU same stimulus → 0x0000_0080. LHU addr 0x...2, rdata 0x8001_1234 → 0x0000_8001. LH addr 0x...0, same rdata → 0x0000_1234.
- LW with 3 wait states, then resp_ready low for 4 cycles → mem_rd_en high for exactly 4 cycles, resp_data 0x8001_1234 stable; req_ready low throughout; IDLE the cycle after resp_ready.
- Assert rst_n low mid-READ, then pulse mem_ack after release → no resp_valid; req_ready=1; all outputs at reset values.
- With LOAD_ADDR_CHECK_EN: LW addr 0x...2 → mem_rd_en never asserted; resp_valid with resp_data 0, resp_err 1. The next aligned LW returns resp_err 0.
- Back-to-back requests with req_valid held high → second accepted only after the first resp handshake; req_op 110 returns the full word.
